// File: rtl/fifo36_drain.sv
// Drain stage between an SRL shortfifo and the packet router: pops the FIFO into a
// 2-entry skid buffer, enforces SOF/EOF framing and keeps packet/error statistics.
module fifo36_drain #(
    parameter int WIDTH   = 36,
    parameter int MAX_LEN = 2048
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] f_data,
    input  logic             f_empty,
    output logic             f_read,
    output logic [WIDTH-1:0] o_data,
    output logic             o_src_rdy,
    input  logic             o_dst_rdy,
    output logic [15:0]      pkt_count,
    output logic [7:0]       err_count,
    output logic             err,
    output logic [1:0]       occupied
);

    typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

    localparam logic [15:0] LAST_LEN = 16'(MAX_LEN - 1);

    state_t           state_reg, state_next;
    logic [15:0]      len_reg, len_next;
    logic [WIDTH-1:0] skid_reg [2];
    logic [1:0]       occ_reg;
    logic [15:0]      pkt_reg;
    logic [7:0]       err_cnt_reg;
    logic             err_reg;

    logic             sof, eof;
    logic             drop_word;
    logic             pop, push, pull;
    logic             err_event, pkt_inc;
    logic [WIDTH-1:0] fwd_data;
    logic [1:0]       wr_idx;

    assign sof = f_data[32];
    assign eof = f_data[33];

    // An SOF arriving in DROP is forwarded, so only non-SOF words may bypass the skid-room check.
    assign drop_word = ~sof & ((state_reg == IDLE) | (state_reg == DROP));
    assign pop       = ~f_empty & ~rst & ~clear & (drop_word | ~occ_reg[1]);
    assign pull      = (occ_reg != 2'd0) & o_dst_rdy;
    assign wr_idx    = occ_reg - {1'b0, pull};

    assign f_read    = pop;
    assign o_data    = skid_reg[0];
    assign o_src_rdy = (occ_reg != 2'd0);
    assign occupied  = occ_reg;
    assign pkt_count = pkt_reg;
    assign err_count = err_cnt_reg;
    assign err       = err_reg;

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        push       = 1'b0;
        fwd_data   = f_data;
        err_event  = 1'b0;
        pkt_inc    = 1'b0;
        if (pop) begin
            if (sof) begin
                push      = 1'b1;
                err_event = (state_reg == PKT);
                len_next  = 16'd1;
                if (eof) begin
                    pkt_inc    = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = PKT;
                end
            end else begin
                case (state_reg)
                    IDLE: err_event = 1'b1;
                    DROP: begin
                        if (eof) state_next = IDLE;
                    end
                    PKT: begin
                        push     = 1'b1;
                        len_next = len_reg + 16'd1;
                        if (eof) begin
                            pkt_inc    = 1'b1;
                            state_next = IDLE;
                        end else if (len_reg == LAST_LEN) begin
                            // Truncate: close the packet here and discard the rest of it.
                            fwd_data[33] = 1'b1;
                            err_event    = 1'b1;
                            pkt_inc      = 1'b1;
                            state_next   = DROP;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_reg   <= IDLE;
            len_reg     <= 16'd0;
            occ_reg     <= 2'd0;
            pkt_reg     <= 16'd0;
            err_cnt_reg <= 8'd0;
            err_reg     <= 1'b0;
            for (int i = 0; i < 2; i++) skid_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            err_reg   <= err_event;
            if (pkt_inc) pkt_reg <= pkt_reg + 16'd1;
            if (err_event && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
            occ_reg <= occ_reg + {1'b0, push} - {1'b0, pull};
            // The pushed word lands behind whatever remains after this cycle's pull.
            for (int i = 0; i < 2; i++) begin
                if (push && wr_idx == 2'(i)) begin
                    skid_reg[i] <= fwd_data;
                end else if (pull && i == 0) begin
                    skid_reg[0] <= skid_reg[1];
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo36_drain.sv
// Randomized scoreboard bench for fifo36_drain: a per-word framing model predicts
// forwarded words, counters and err pulses; a negedge monitor compares transfers.
module tb_fifo36_drain;

    localparam int WIDTH   = 36;
    localparam int MAX_LEN = 4;
    localparam int M_IDLE  = 0;
    localparam int M_PKT   = 1;
    localparam int M_DROP  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear = 1'b0;
    logic [WIDTH-1:0] f_data = '0;
    logic             f_empty = 1'b1;
    logic             f_read;
    logic [WIDTH-1:0] o_data;
    logic             o_src_rdy;
    logic             o_dst_rdy = 1'b0;
    logic [15:0]      pkt_count;
    logic [7:0]       err_count;
    logic             err;
    logic [1:0]       occupied;

    always #5 clk = ~clk;

    fifo36_drain #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .f_data(f_data), .f_empty(f_empty), .f_read(f_read),
        .o_data(o_data), .o_src_rdy(o_src_rdy), .o_dst_rdy(o_dst_rdy),
        .pkt_count(pkt_count), .err_count(err_count), .err(err), .occupied(occupied)
    );

    int               vectors = 0;
    int               miscompares = 0;
    logic [WIDTH-1:0] src_q[$];
    logic [WIDTH-1:0] exp_q[$];
    int               mstate = M_IDLE;
    int               mlen = 0;
    int               mpkts = 0;
    int               merrs = 0;
    int               model_occ = 0;
    bit               exp_err = 1'b0;
    bit               chk_en = 1'b0;
    bit               rand_mode = 1'b0;
    int               dst_mode = 1;
    int               seq = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h at t=%0t", name, act, req, $time);
        end
    endfunction

    function automatic logic [WIDTH-1:0] mk(bit sof, bit eof);
        seq++;
        return {2'($urandom_range(0, 3)), eof, sof, 32'(seq)};
    endfunction

    function automatic bit would_discard(logic [WIDTH-1:0] w);
        return !w[32] && (mstate != M_PKT);
    endfunction

    function automatic void fwd(logic [WIDTH-1:0] w);
        exp_q.push_back(w);
        model_occ++;
    endfunction

    function automatic void flag_err();
        merrs++;
        exp_err = 1'b1;
    endfunction

    // Framing rules applied to each word as the FIFO hands it over.
    function automatic void model_pop(logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] o;
        o = w;
        if (w[32]) begin
            if (mstate == M_PKT) flag_err();
            fwd(w);
            mlen = 1;
            if (w[33]) begin
                mpkts++;
                mstate = M_IDLE;
            end else begin
                mstate = M_PKT;
            end
        end else if (mstate == M_IDLE) begin
            flag_err();
        end else if (mstate == M_DROP) begin
            if (w[33]) mstate = M_IDLE;
        end else begin
            mlen++;
            if (w[33]) begin
                fwd(w);
                mpkts++;
                mstate = M_IDLE;
            end else if (mlen == MAX_LEN) begin
                o[33] = 1'b1;
                fwd(o);
                flag_err();
                mpkts++;
                mstate = M_DROP;
            end else begin
                fwd(w);
            end
        end
    endfunction

    task automatic tick(bit do_clear = 1'b0);
        bit rd, xfer, exp_rd;
        logic [WIDTH-1:0] w;
        clear = do_clear;
        case (dst_mode)
            0:       o_dst_rdy = 1'b0;
            1:       o_dst_rdy = 1'b1;
            default: o_dst_rdy = 1'($urandom_range(0, 1));
        endcase
        if (do_clear) o_dst_rdy = 1'b0;
        if (src_q.size() == 0 || (rand_mode && $urandom_range(0, 3) == 0)) begin
            f_empty = 1'b1;
            f_data  = {4'($urandom), 32'($urandom)};
        end else begin
            f_empty = 1'b0;
            f_data  = src_q[0];
        end
        @(negedge clk);
        rd     = f_read;
        exp_rd = !f_empty && !rst && !clear && (would_discard(f_data) || model_occ < 2);
        check("f_read", 64'(rd), 64'(exp_rd));
        xfer = (model_occ > 0) && o_dst_rdy;
        @(posedge clk);
        #1;
        exp_err = 1'b0;
        if (rst || clear) begin
            mstate = M_IDLE; mlen = 0; mpkts = 0; merrs = 0; model_occ = 0;
            exp_q.delete();
        end else begin
            if (rd && !f_empty) begin
                w = src_q.pop_front();
                model_pop(w);
            end
            if (xfer) model_occ--;
        end
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        while ((src_q.size() != 0 || model_occ != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain done", 64'(src_q.size() == 0 && model_occ == 0), 64'd1);
    endtask

    task automatic push_pkt(int n);
        for (int i = 0; i < n; i++) src_q.push_back(mk(i == 0, i == n - 1));
    endtask

    task automatic gen_random();
        int r, n;
        bit s, e;
        r = $urandom_range(0, 9);
        if (r == 0) begin
            src_q.push_back(mk(1'b0, 1'($urandom_range(0, 1))));
        end else if (r == 1) begin
            src_q.push_back(mk(1'b1, 1'b1));
        end else begin
            n = $urandom_range(2, 7);
            for (int i = 0; i < n; i++) begin
                s = (i == 0) || ($urandom_range(0, 15) == 0);
                e = (i == n - 1) && ($urandom_range(0, 7) != 0);
                src_q.push_back(mk(s, e));
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("occupied", 64'(occupied), 64'(model_occ));
            check("o_src_rdy", 64'(o_src_rdy), 64'(model_occ != 0));
            check("pkt_count", 64'(pkt_count), 64'(mpkts & 16'hFFFF));
            check("err_count", 64'(err_count), 64'((merrs > 255) ? 255 : merrs));
            check("err", 64'(err), 64'(exp_err));
            if (o_src_rdy && o_dst_rdy) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL o_data: transfer of %0h with no word required at t=%0t", o_data, $time);
                end else begin
                    check("o_data", 64'(o_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("reset o_data", 64'(o_data), 64'd0);
        check("reset o_src_rdy", 64'(o_src_rdy), 64'd0);
        check("reset f_read", 64'(f_read), 64'd0);
        check("reset occupied", 64'(occupied), 64'd0);
        check("reset pkt_count", 64'(pkt_count), 64'd0);
        check("reset err_count", 64'(err_count), 64'd0);
        check("reset err", 64'(err), 64'd0);
        chk_en = 1'b1;

        // Streaming packet at full rate.
        dst_mode = 1;
        push_pkt(4);
        drain(50);
        check("stream pkt_count", 64'(pkt_count), 64'd1);

        // Backpressure: only two words may enter the skid.
        dst_mode = 0;
        push_pkt(4);
        repeat (6) tick();
        check("bp occupied", 64'(occupied), 64'd2);
        check("bp pops", 64'(src_q.size()), 64'd2);
        dst_mode = 1;
        drain(50);

        // Leading garbage then a 2-word packet.
        for (int i = 0; i < 3; i++) src_q.push_back(mk(1'b0, 1'b0));
        push_pkt(2);
        drain(50);
        check("garbage err_count", 64'(err_count), 64'd3);

        // Over-length 7-word packet, then an intact one.
        push_pkt(7);
        push_pkt(3);
        drain(50);
        check("overlen err_count", 64'(err_count), 64'd4);
        check("overlen pkt_count", 64'(pkt_count), 64'd5);

        // SOF inside a packet, then a single-word packet.
        src_q.push_back(mk(1'b1, 1'b0));
        src_q.push_back(mk(1'b0, 1'b0));
        src_q.push_back(mk(1'b1, 1'b0));
        src_q.push_back(mk(1'b0, 1'b0));
        src_q.push_back(mk(1'b0, 1'b1));
        src_q.push_back(mk(1'b1, 1'b1));
        drain(50);
        check("sof-in-pkt err_count", 64'(err_count), 64'd5);
        check("sof-in-pkt pkt_count", 64'(pkt_count), 64'd7);

        // Clear in the middle of a 6-word packet.
        dst_mode = 0;
        push_pkt(6);
        k = 0;
        while (src_q.size() > 4 && k < 20) begin
            tick();
            k++;
        end
        tick(1'b1);
        check("clear occupied", 64'(occupied), 64'd0);
        check("clear o_src_rdy", 64'(o_src_rdy), 64'd0);
        check("clear pkt_count", 64'(pkt_count), 64'd0);
        check("clear err_count", 64'(err_count), 64'd0);
        dst_mode = 1;
        drain(50);

        // Randomized traffic with bubbles, backpressure and occasional clears.
        rand_mode = 1'b1;
        dst_mode  = 2;
        for (int c = 0; c < 3000; c++) begin
            if (src_q.size() < 4) gen_random();
            tick($urandom_range(0, 299) == 0);
        end
        rand_mode = 1'b0;
        dst_mode  = 1;
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
